// File: rtl/hazard3_ahbl_sram_resp.sv
// AHB-Lite SRAM responder: word-organised memory with optional wait states,
// two-cycle ERROR responses and a single-entry exclusive-access monitor.
module hazard3_ahbl_sram_resp #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    output logic              ahbls_hexokay,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic              ahbls_hexcl,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    localparam logic [W_ADDR:0] MEM_BYTES = {(W_ADDR - 1)'(DEPTH), 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic xfer_err(input logic [W_ADDR-1:0] a, input logic [2:0] sz);
        return ({1'b0, a} >= MEM_BYTES) || (sz > 3'd2) ||
               ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << lo;
            2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    logic [W_DATA-1:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q;
    logic [1:0]      size_q;
    logic            write_q, excl_q;
    logic            resv_valid_q, resv_valid_d;
    logic [AW-1:0]   resv_addr_q, resv_addr_d;

    logic            accept_s, addr_err_s, resv_hit_s, wr_commit_s;
    logic [AW-1:0]   word_s;
    logic [3:0]      be_s;
    logic            unused_s;

    assign unused_s    = ahbls_htrans[0];
    assign word_s      = addr_q[AW+1:2];
    assign be_s        = lane_mask(size_q, addr_q[1:0]);
    assign addr_err_s  = xfer_err(ahbls_haddr, ahbls_hsize);
    assign accept_s    = ahbls_hready && ahbls_htrans[1] &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2));
    assign resv_hit_s  = resv_valid_q && (resv_addr_q == word_s);
    // A failed exclusive write still completes OKAY but must not touch memory.
    assign wr_commit_s = (state_q == ST_DONE) && write_q && (!excl_q || resv_hit_s);

    assign ahbls_hready_resp = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign ahbls_hresp       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign ahbls_hexokay     = (state_q == ST_DONE) && excl_q && (!write_q || resv_hit_s);
    assign ahbls_hrdata      = ((state_q == ST_DONE) && !write_q) ? mem[word_s] : {W_DATA{1'b0}};

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (addr_err_s) begin
                    state_d = ST_ERR1;
                end else if (WAIT_CYCLES == 0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reservation update; a newly accepted erroring exclusive overrides the completing one
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        if (state_q == ST_DONE) begin
            if (write_q) begin
                if (excl_q || resv_hit_s) begin
                    resv_valid_d = 1'b0;
                end else begin
                    resv_valid_d = resv_valid_q;
                end
            end else if (excl_q) begin
                resv_valid_d = 1'b1;
                resv_addr_d  = word_s;
            end else begin
                resv_valid_d = resv_valid_q;
            end
        end else begin
            resv_valid_d = resv_valid_q;
        end
        if (accept_s && addr_err_s && ahbls_hexcl) begin
            resv_valid_d = 1'b0;
        end else begin
            resv_addr_d = resv_addr_d;
        end
    end

    // Control and data-phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= 2'd0;
            write_q      <= 1'b0;
            excl_q       <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            if (accept_s) begin
                addr_q  <= ahbls_haddr[AW+1:0];
                size_q  <= ahbls_hsize[1:0];
                write_q <= ahbls_hwrite;
                excl_q  <= ahbls_hexcl;
            end
        end
    end

    // Byte-lane write commit at the end of DONE
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem[word_s][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard3_ahbl_sram_resp.sv
// Directed bench: two responders (0 and 2 wait states) driven by a pipelined AHB-Lite master task.
module tb_hazard3_ahbl_sram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hexcl;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    logic        rdy0, rsp0, xok0, rdy2, rsp2, xok2;
    logic [31:0] rd0, rd2;
    logic [1:0]  htrans0, htrans2;
    logic        o_rdy, o_rsp, o_xok;
    logic [31:0] o_rd;

    int tests = 0;
    int fails = 0;
    int xok_bad;

    logic [31:0] t_addr [8];
    logic [31:0] t_wd   [8];
    logic        t_wr   [8];
    logic        t_ex   [8];
    logic [2:0]  t_sz   [8];
    int          r_stall  [8];
    logic        r_rsp_st [8];
    logic        r_rsp    [8];
    logic        r_xok    [8];
    logic        r_done   [8];
    logic [31:0] r_rd     [8];

    always #5 clk = ~clk;

    assign htrans0 = sel ? 2'b00 : htrans;
    assign htrans2 = sel ? htrans : 2'b00;
    assign o_rdy   = sel ? rdy2 : rdy0;
    assign o_rsp   = sel ? rsp2 : rsp0;
    assign o_xok   = sel ? xok2 : xok0;
    assign o_rd    = sel ? rd2  : rd0;

    hazard3_ahbl_sram_resp #(.W_ADDR(32), .W_DATA(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ahbls_hready(rdy0), .ahbls_hready_resp(rdy0),
        .ahbls_hresp(rsp0), .ahbls_hexokay(xok0), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans0), .ahbls_hsize(hsize), .ahbls_hexcl(hexcl),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(rd0)
    );

    hazard3_ahbl_sram_resp #(.W_ADDR(32), .W_DATA(32), .DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ahbls_hready(rdy2), .ahbls_hready_resp(rdy2),
        .ahbls_hresp(rsp2), .ahbls_hexokay(xok2), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans2), .ahbls_hsize(hsize), .ahbls_hexcl(hexcl),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(rd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int i, input logic wr, input logic [2:0] sz, input logic ex,
                          input logic [31:0] a, input logic [31:0] wd);
        t_wr[i] = wr; t_sz[i] = sz; t_ex[i] = ex; t_addr[i] = a; t_wd[i] = wd;
    endtask

    // Issue n transfers back-to-back; address of i+1 overlaps the data phase of i.
    task automatic run(input int n);
        int   idx, dph, cyc;
        logic rdy;
        idx = 0; dph = -1; cyc = 0; xok_bad = 0;
        for (int i = 0; i < 8; i++) begin
            r_stall[i] = 0; r_rsp_st[i] = 1'b0; r_rsp[i] = 1'b0;
            r_xok[i] = 1'b0; r_done[i] = 1'b0; r_rd[i] = 32'd0;
        end
        while ((idx < n || dph >= 0) && cyc < 100) begin
            if (idx < n) begin
                htrans = 2'b10; haddr = t_addr[idx]; hwrite = t_wr[idx];
                hsize = t_sz[idx]; hexcl = t_ex[idx];
            end else begin
                htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd0; hexcl = 1'b0;
            end
            hwdata = (dph >= 0) ? t_wd[dph] : 32'd0;
            @(negedge clk);
            rdy = o_rdy;
            if (dph >= 0 && !rdy) begin
                r_stall[dph]++;
                r_rsp_st[dph] = r_rsp_st[dph] | o_rsp;
                if (o_xok !== 1'b0) xok_bad++;
            end else if (dph >= 0) begin
                r_rsp[dph] = o_rsp; r_rd[dph] = o_rd; r_xok[dph] = o_xok; r_done[dph] = 1'b1;
            end else if (o_xok !== 1'b0) begin
                xok_bad++;
            end
            @(posedge clk); #1;
            if (rdy) begin
                if (idx < n) begin
                    dph = idx; idx++;
                end else begin
                    dph = -1;
                end
            end
            cyc++;
        end
        htrans = 2'b00;
        chk("hexokay_outside_done", xok_bad, 0);
    endtask

    task automatic exp_tx(input string tag, input int i, input int st, input logic rsp,
                          input logic xok, input bit crd, input logic [31:0] rd);
        chk({tag, "_done"},   r_done[i], 1'b1);
        chk({tag, "_stall"},  r_stall[i], st);
        chk({tag, "_hresp"},  r_rsp[i], rsp);
        chk({tag, "_hresp_stall"}, r_rsp_st[i], (st > 0) ? rsp : 1'b0);
        chk({tag, "_hexokay"}, r_xok[i], xok);
        if (crd) chk({tag, "_hrdata"}, r_rd[i], rd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy0"}, rdy0, 1'b1); chk({tag, "_rsp0"}, rsp0, 1'b0);
        chk({tag, "_xok0"}, xok0, 1'b0); chk({tag, "_rd0"},  rd0, 32'd0);
        chk({tag, "_rdy2"}, rdy2, 1'b1); chk({tag, "_rsp2"}, rsp2, 1'b0);
        chk({tag, "_xok2"}, xok2, 1'b0); chk({tag, "_rd2"},  rd2, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; htrans = 2'b00; haddr = 32'd0; hwdata = 32'd0;
        hwrite = 1'b0; hexcl = 1'b0; hsize = 3'd0;
        #2;
        chk_reset_outputs("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // word write then read, zero wait states
        set_tx(0, 1'b1, 3'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        set_tx(1, 1'b0, 3'd2, 1'b0, 32'h10, 32'd0);
        run(2);
        exp_tx("w_word", 0, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("r_word", 1, 0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);

        // byte and halfword lanes
        set_tx(0, 1'b1, 3'd2, 1'b0, 32'h10, 32'h11223344);
        set_tx(1, 1'b1, 3'd0, 1'b0, 32'h13, 32'hAA000000);
        set_tx(2, 1'b0, 3'd2, 1'b0, 32'h10, 32'd0);
        set_tx(3, 1'b1, 3'd1, 1'b0, 32'h12, 32'h55660000);
        set_tx(4, 1'b0, 3'd2, 1'b0, 32'h10, 32'd0);
        run(5);
        exp_tx("r_after_byte", 2, 0, 1'b0, 1'b0, 1'b1, 32'hAA223344);
        exp_tx("r_after_half", 4, 0, 1'b0, 1'b0, 1'b1, 32'h55663344);

        // error responses, each followed by a transfer accepted in ERR2
        set_tx(0, 1'b1, 3'd2, 1'b0, 32'hFC,  32'hCAFEF00D);
        set_tx(1, 1'b0, 3'd2, 1'b0, 32'h100, 32'd0);
        set_tx(2, 1'b0, 3'd2, 1'b0, 32'h2,   32'd0);
        set_tx(3, 1'b1, 3'd3, 1'b0, 32'h10,  32'hFFFFFFFF);
        set_tx(4, 1'b0, 3'd1, 1'b0, 32'h11,  32'd0);
        set_tx(5, 1'b0, 3'd2, 1'b0, 32'hFC,  32'd0);
        set_tx(6, 1'b0, 3'd2, 1'b0, 32'h10,  32'd0);
        run(7);
        exp_tx("err_range",  1, 1, 1'b1, 1'b0, 1'b1, 32'd0);
        exp_tx("err_align",  2, 1, 1'b1, 1'b0, 1'b1, 32'd0);
        exp_tx("err_size",   3, 1, 1'b1, 1'b0, 1'b1, 32'd0);
        exp_tx("err_half",   4, 1, 1'b1, 1'b0, 1'b1, 32'd0);
        exp_tx("r_last_word", 5, 0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        exp_tx("r_no_err_wr", 6, 0, 1'b0, 1'b0, 1'b1, 32'h55663344);

        // exclusive pair succeeds, repeat fails
        set_tx(0, 1'b1, 3'd2, 1'b0, 32'h44, 32'h12345678);
        set_tx(1, 1'b0, 3'd2, 1'b1, 32'h40, 32'd0);
        set_tx(2, 1'b1, 3'd2, 1'b1, 32'h40, 32'h7);
        set_tx(3, 1'b1, 3'd2, 1'b1, 32'h40, 32'h9);
        set_tx(4, 1'b0, 3'd2, 1'b0, 32'h40, 32'd0);
        run(5);
        exp_tx("ex_rd",      1, 0, 1'b0, 1'b1, 1'b0, 32'd0);
        exp_tx("ex_wr_ok",   2, 0, 1'b0, 1'b1, 1'b1, 32'd0);
        exp_tx("ex_wr_fail", 3, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("ex_rd_back", 4, 0, 1'b0, 1'b0, 1'b1, 32'h7);

        // plain write to the reserved word breaks the reservation
        set_tx(0, 1'b0, 3'd2, 1'b1, 32'h40, 32'd0);
        set_tx(1, 1'b1, 3'd2, 1'b0, 32'h40, 32'h3);
        set_tx(2, 1'b1, 3'd2, 1'b1, 32'h40, 32'h5);
        set_tx(3, 1'b0, 3'd2, 1'b0, 32'h40, 32'd0);
        run(4);
        exp_tx("ex2_rd",      0, 0, 1'b0, 1'b1, 1'b1, 32'h7);
        exp_tx("ex2_wr_fail", 2, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("ex2_rd_back", 3, 0, 1'b0, 1'b0, 1'b1, 32'h3);

        // erroring exclusive clears the reservation
        set_tx(0, 1'b0, 3'd2, 1'b1, 32'h44, 32'd0);
        set_tx(1, 1'b1, 3'd2, 1'b1, 32'h46, 32'h1);
        set_tx(2, 1'b1, 3'd2, 1'b1, 32'h44, 32'h8);
        set_tx(3, 1'b0, 3'd2, 1'b0, 32'h44, 32'd0);
        run(4);
        exp_tx("ex3_rd",      0, 0, 1'b0, 1'b1, 1'b1, 32'h12345678);
        exp_tx("ex3_err",     1, 1, 1'b1, 1'b0, 1'b1, 32'd0);
        exp_tx("ex3_wr_fail", 2, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("ex3_rd_back", 3, 0, 1'b0, 1'b0, 1'b1, 32'h12345678);

        // plain read elsewhere keeps the reservation
        set_tx(0, 1'b0, 3'd2, 1'b1, 32'h48, 32'd0);
        set_tx(1, 1'b0, 3'd2, 1'b0, 32'h40, 32'd0);
        set_tx(2, 1'b1, 3'd2, 1'b1, 32'h48, 32'hA);
        set_tx(3, 1'b0, 3'd2, 1'b0, 32'h48, 32'd0);
        run(4);
        exp_tx("ex4_plain_rd", 1, 0, 1'b0, 1'b0, 1'b1, 32'h3);
        exp_tx("ex4_wr_ok",    2, 0, 1'b0, 1'b1, 1'b1, 32'd0);
        exp_tx("ex4_rd_back",  3, 0, 1'b0, 1'b0, 1'b1, 32'hA);

        // reservation on responder 0 to be wiped by reset later
        set_tx(0, 1'b0, 3'd2, 1'b1, 32'h40, 32'd0);
        run(1);
        exp_tx("ex5_rd", 0, 0, 1'b0, 1'b1, 1'b1, 32'h3);

        // two wait states, back-to-back write then read
        sel = 1'b1;
        set_tx(0, 1'b1, 3'd2, 1'b0, 32'h20, 32'h1);
        set_tx(1, 1'b0, 3'd2, 1'b0, 32'h20, 32'd0);
        run(2);
        exp_tx("w2_wr", 0, 2, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("w2_rd", 1, 2, 1'b0, 1'b0, 1'b1, 32'h1);

        // reset in the middle of a stalled write
        htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("mid_wait_stall", rdy2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        set_tx(0, 1'b0, 3'd2, 1'b0, 32'h20, 32'd0);
        run(1);
        exp_tx("rst_rd", 0, 2, 1'b0, 1'b0, 1'b1, 32'h1);

        sel = 1'b0;
        set_tx(0, 1'b1, 3'd2, 1'b1, 32'h40, 32'hB);
        set_tx(1, 1'b0, 3'd2, 1'b0, 32'h40, 32'd0);
        run(2);
        exp_tx("rst_ex_wr",  0, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        exp_tx("rst_ex_rdb", 1, 0, 1'b0, 1'b0, 1'b1, 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
